uart_rx_ctrl: RTL and testbench

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_rx_ctrl_pkg.sv | 16 +
 rtl/uart_rx_ctrl_fifo.sv | 54 +++++
 rtl/uart_rx_ctrl.sv | 108 ++++++++++
 tb/tb_uart_rx_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_ctrl_pkg.sv
// Shared UART constants and receive-capture FSM encodings.
package uart_rx_ctrl_pkg;

  localparam int          UART_DATA_BITS  = 8;
  localparam int          UART_OVERSAMPLE = 8;
  localparam int          UART_LEVEL_W    = 5;
  localparam logic [15:0] DIV_RST_DEF     = 16'd53;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CAPTURE  = 2'd1,
    CLEAR    = 2'd2,
    WAIT_LOW = 2'd3
  } cap_state_t;

endpackage

// File: rtl/uart_rx_ctrl_fifo.sv
// Show-ahead receive byte FIFO with occupancy count.
module rx_fifo
  import uart_rx_ctrl_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic [UART_DATA_BITS-1:0] wdata,
  output logic [UART_DATA_BITS-1:0] rdata,
  output logic [UART_LEVEL_W-1:0]   level,
  output logic                      full,
  output logic                      empty
);

  localparam int AW = $clog2(DEPTH);

  logic [UART_DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]             wp;
  logic [AW-1:0]             rp;
  logic [UART_LEVEL_W-1:0]   cnt;
  logic                      do_push;
  logic                      do_pop;

  assign full  = (cnt == UART_LEVEL_W'(DEPTH));
  assign empty = (cnt == '0);
  assign level = cnt;

  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign rdata = empty ? '0 : mem[rp];

  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      cnt <= cnt + UART_LEVEL_W'(do_push)
                 - UART_LEVEL_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wdata;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Glue between UART receive unit and CPU: sample tick,
// byte capture handshake, receive FIFO and interrupt.
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int          DEPTH   = 8,
  parameter logic [15:0] DIV_RST = DIV_RST_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        div_we,
  input  logic [15:0] div_wdata,
  input  logic [3:0]  thresh,
  input  logic        rx_rs,
  input  logic [7:0]  rx_data,
  output logic        en_rx,
  output logic        over_read,
  input  logic        rd_en,
  output logic [7:0]  rd_data,
  output logic [4:0]  level,
  output logic        empty,
  output logic        full,
  output logic        overrun,
  input  logic        ovr_clr,
  output logic        irq
);

  logic [15:0] div_q;
  logic [15:0] cnt_q;
  logic        en_q;
  cap_state_t  state_q;
  cap_state_t  state_d;
  logic        cap;
  logic        drop;
  logic [4:0]  thr;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= DIV_RST;
      cnt_q <= '0;
      en_q  <= 1'b0;
    end else if (div_we) begin
      div_q <= div_wdata;
      cnt_q <= '0;
      en_q  <= 1'b0;
    end else if (cnt_q == div_q) begin
      cnt_q <= '0;
      en_q  <= 1'b1;
    end else begin
      cnt_q <= cnt_q + 16'd1;
      en_q  <= 1'b0;
    end
  end

  assign en_rx = en_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    over_read = 1'b0;
    cap       = 1'b0;
    unique case (state_q)
      IDLE:     if (rx_rs) state_d = CAPTURE;
      CAPTURE: begin
        cap     = 1'b1;
        state_d = CLEAR;
      end
      CLEAR: begin
        over_read = 1'b1;
        state_d   = WAIT_LOW;
      end
      WAIT_LOW: if (!rx_rs) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  rx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cap),
    .pop   (rd_en),
    .wdata (rx_data),
    .rdata (rd_data),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  assign drop = cap && full && !rd_en;

  always_ff @(posedge clk) begin
    if (rst)          overrun <= 1'b0;
    else if (drop)    overrun <= 1'b1;
    else if (ovr_clr) overrun <= 1'b0;
  end

  assign thr = (thresh == 4'd0) ? 5'd1 : {1'b0, thresh};

  always_ff @(posedge clk) begin
    if (rst) irq <= 1'b0;
    else     irq <= (level >= thr) || overrun;
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Random + directed bench for uart_rx_ctrl against a
// queue-based behavioural model.
module tb_uart_rx_ctrl;

  localparam int          DEPTH = 8;
  localparam logic [15:0] DIV   = 16'd53;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        div_we = 1'b0;
  logic [15:0] div_wdata = '0;
  logic [3:0]  thresh = 4'd1;
  logic        rx_rs = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        en_rx;
  logic        over_read;
  logic        rd_en = 1'b0;
  logic [7:0]  rd_data;
  logic [4:0]  level;
  logic        empty;
  logic        full;
  logic        overrun;
  logic        ovr_clr = 1'b0;
  logic        irq;

  int vectors = 0;
  int miscompares = 0;

  uart_rx_ctrl #(.DEPTH(DEPTH), .DIV_RST(DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .div_we    (div_we),
    .div_wdata (div_wdata),
    .thresh    (thresh),
    .rx_rs     (rx_rs),
    .rx_data   (rx_data),
    .en_rx     (en_rx),
    .over_read (over_read),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .level     (level),
    .empty     (empty),
    .full      (full),
    .overrun   (overrun),
    .ovr_clr   (ovr_clr),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  // Model state: tick as edges-since-load modulo (div+1),
  // FIFO as a queue, capture as a handshake phase.
  logic [15:0] mdiv;
  int          mk;
  bit          men;
  logic [7:0]  mq [$];
  bit          movr;
  bit          mirq;
  int          mph;
  bit          mvalid = 0;

  task automatic model_step();
    int th;
    bit full_m, popd, ovset, nirq;
    if (rst) begin
      mdiv = DIV; mk = 0; men = 0;
      mq.delete(); movr = 0; mirq = 0;
      mph = 0; mvalid = 1;
    end else begin
      th = (thresh == 4'd0) ? 1 : int'(thresh);
      nirq = (mq.size() >= th) || movr;
      if (div_we) begin
        mdiv = div_wdata; mk = 0; men = 0;
      end else begin
        mk++;
        men = (mk % (int'(mdiv) + 1)) == 0;
      end
      full_m = (mq.size() == DEPTH);
      popd = rd_en && (mq.size() > 0);
      ovset = 0;
      if (popd) void'(mq.pop_front());
      if (mph == 1) begin
        if (!full_m || rd_en) mq.push_back(rx_data);
        else ovset = 1;
      end
      if (ovset) movr = 1;
      else if (ovr_clr) movr = 0;
      case (mph)
        0: if (rx_rs) mph = 1;
        1: mph = 2;
        2: mph = 3;
        default: if (!rx_rs) mph = 0;
      endcase
      mirq = nirq;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  task automatic cmp(string nm, int act, int exp);
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (mvalid) begin
      vectors++;
      cmp("m_en_rx", int'(en_rx), int'(men));
      cmp("m_over_read", int'(over_read), int'(mph == 2));
      cmp("m_level", int'(level), mq.size());
      cmp("m_empty", int'(empty), int'(mq.size() == 0));
      cmp("m_full", int'(full), int'(mq.size() == DEPTH));
      cmp("m_overrun", int'(overrun), int'(movr));
      cmp("m_irq", int'(irq), int'(mirq));
      cmp("m_rd_data", int'(rd_data),
          mq.size() > 0 ? int'(mq[0]) : 0);
    end
  end

  task automatic chk(string nm, int act, int exp);
    vectors++;
    cmp(nm, act, exp);
  endtask

  task automatic cyc(int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    rx_rs = 1'b1;
    rx_data = b;
    n = 0;
    do begin
      cyc(1);
      n++;
    end while (!over_read && n < 10);
    vectors++;
    if (!over_read) begin
      miscompares++;
      $display("FAIL send_timeout: got no over_read expected pulse");
    end
    rx_rs = 1'b0;
    cyc(2);
  endtask

  task automatic pop_n(int n);
    repeat (n) begin
      rd_en = 1'b1;
      cyc(1);
    end
    rd_en = 1'b0;
  endtask

  int cnt_or;
  int gap;
  int hold;
  int rate;

  initial begin
    cyc(3);
    chk("rst_level", int'(level), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_en_rx", int'(en_rx), 0);
    chk("rst_irq", int'(irq), 0);
    chk("rst_rd_data", int'(rd_data), 0);
    rst = 1'b0;
    cyc(1);
    chk("rst_over_read", int'(over_read), 0);
    chk("rst_overrun", int'(overrun), 0);

    div_we = 1'b1; div_wdata = 16'd3;
    cyc(1);
    div_we = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      cyc(1);
      chk("tick_div3", int'(en_rx), int'(n % 4 == 0));
    end
    div_we = 1'b1; div_wdata = 16'd0;
    cyc(1);
    div_we = 1'b0;
    for (int n = 0; n < 5; n++) begin
      cyc(1);
      chk("tick_div0", int'(en_rx), 1);
    end
    div_we = 1'b1; div_wdata = 16'd7;
    cyc(1);
    div_we = 1'b0;

    thresh = 4'd1;
    rx_rs = 1'b1; rx_data = 8'hA5;
    cyc(1);
    chk("a5_or_early", int'(over_read), 0);
    cyc(1);
    chk("a5_or_pulse", int'(over_read), 1);
    chk("a5_level", int'(level), 1);
    chk("a5_rd_data", int'(rd_data), 8'hA5);
    rx_rs = 1'b0;
    cyc(1);
    chk("a5_or_width", int'(over_read), 0);
    chk("a5_irq", int'(irq), 1);
    cyc(1);
    pop_n(1);
    cyc(1);

    for (int i = 1; i <= 9; i++) send_byte(8'(i));
    chk("ovf_full", int'(full), 1);
    chk("ovf_overrun", int'(overrun), 1);
    chk("ovf_level", int'(level), 8);
    for (int i = 1; i <= 8; i++) begin
      chk("ovf_order", int'(rd_data), i);
      pop_n(1);
    end
    chk("ovf_empty", int'(empty), 1);

    ovr_clr = 1'b1;
    cyc(1);
    ovr_clr = 1'b0;
    for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i));
    rx_rs = 1'b1; rx_data = 8'h18;
    cyc(1);
    rd_en = 1'b1;
    cyc(1);
    rd_en = 1'b0;
    rx_rs = 1'b0;
    chk("pp_level", int'(level), 8);
    chk("pp_overrun", int'(overrun), 0);
    cyc(2);
    for (int i = 1; i <= 8; i++) begin
      chk("pp_order", int'(rd_data), 8'h10 + i);
      pop_n(1);
    end

    pop_n(1);
    chk("mt_level", int'(level), 0);
    chk("mt_rd_data", int'(rd_data), 0);

    for (int i = 0; i < 8; i++) send_byte(8'h30 + 8'(i));
    rx_rs = 1'b1; rx_data = 8'h99;
    cyc(1);
    ovr_clr = 1'b1;
    cyc(1);
    ovr_clr = 1'b0;
    rx_rs = 1'b0;
    cyc(1);
    chk("clr_vs_set", int'(overrun), 1);
    cyc(1);
    ovr_clr = 1'b1;
    cyc(1);
    ovr_clr = 1'b0;
    pop_n(8);

    rx_rs = 1'b1; rx_data = 8'h55;
    cyc(2);
    chk("rc_or_pre", int'(over_read), 1);
    rst = 1'b1;
    cyc(1);
    chk("rc_or_rst", int'(over_read), 0);
    chk("rc_level", int'(level), 0);
    rst = 1'b0;
    cnt_or = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      if (over_read) cnt_or++;
    end
    chk("rc_one_capture", cnt_or, 1);
    chk("rc_level2", int'(level), 1);
    chk("rc_data", int'(rd_data), 8'h55);
    rx_rs = 1'b0;
    cyc(2);
    pop_n(1);

    gap = 0; hold = -1; rate = 30;
    for (int c = 0; c < 4000; c++) begin
      if (c % 400 == 0) begin
        case ($urandom_range(0, 2))
          0: rate = 0;
          1: rate = 10;
          default: rate = 50;
        endcase
      end
      rd_en = ($urandom_range(0, 99) < rate);
      ovr_clr = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 199) == 0) thresh = 4'($urandom);
      div_we = ($urandom_range(0, 299) == 0);
      div_wdata = 16'($urandom_range(0, 5));
      if (rx_rs) begin
        if (mph == 2) hold = $urandom_range(0, 3);
        else if (hold > 0) hold--;
        if (hold == 0) begin
          rx_rs = 1'b0;
          hold = -1;
          gap = $urandom_range(0, 12);
        end
      end else if (gap > 0) begin
        gap--;
      end else begin
        rx_rs = 1'b1;
        rx_data = 8'($urandom);
      end
      cyc(1);
    end
    rx_rs = 1'b0; rd_en = 1'b0;
    ovr_clr = 1'b0; div_we = 1'b0;
    cyc(10);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
